// File: rtl/control_unit.sv
// control_unit: instruction decode plus a small debug controller.
//
// Decode (combinational from the instruction fields):
//   opcode[6:0]                -> RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, Jump, ALUOp
//   ALUOp, funct3, funct7[5]   -> ALUControl[3:0]
//
// Debug controller (clocked on clk, asynchronous active-low reset):
//   enable, rd_wr, address, data_out -> debug register access (0x0 DCTRL, 0x4 DSTATUS,
//                                       0x8 DBP, 0xC DSCRATCH)
//   data_in                          -> registered read data
//   run, step                        -> rising-edge sensitive debugger commands
//   pc                               -> compared against DBP for breakpoints
//   halt                             -> CPU stall request (registered)
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [1:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        Branch,
    output logic        Jump,
    output logic [3:0]  ALUControl,
    input  logic [31:0] pc,
    input  logic        enable,
    input  logic        rd_wr,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    input  logic        step,
    input  logic        run,
    output logic        halt
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluSll  = 4'b0010;
    localparam logic [3:0] AluSlt  = 4'b0011;
    localparam logic [3:0] AluSltu = 4'b0100;
    localparam logic [3:0] AluXor  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluOr   = 4'b1000;
    localparam logic [3:0] AluAnd  = 4'b1001;

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    always_comb begin
        ALUOp    = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        case (opcode)
            OpR: begin
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OpIAlu: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b11;
            end
            OpLoad: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
            end
            OpStore: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OpBr: begin
                Branch   = 1'b1;
                ALUOp    = 2'b01;
            end
            OpJal, OpJalr: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                Jump     = 1'b1;
            end
            OpLui, OpAuipc: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU control
    // ------------------------------------------------------------------
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ALUControl = AluAdd;
        case (ALUOp)
            2'b00: ALUControl = AluAdd;
            2'b01: ALUControl = AluSub;
            default: begin
                case (funct3)
                    // Immediate forms have no SUB; funct7 there is immediate bits.
                    3'b000: ALUControl = (ALUOp == 2'b10 && funct7[5]) ? AluSub : AluAdd;
                    3'b001: ALUControl = AluSll;
                    3'b010: ALUControl = AluSlt;
                    3'b011: ALUControl = AluSltu;
                    3'b100: ALUControl = AluXor;
                    3'b101: ALUControl = funct7[5] ? AluSra : AluSrl;
                    3'b110: ALUControl = AluOr;
                    default: ALUControl = AluAnd;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Debug controller
    // ------------------------------------------------------------------
    logic        halt_q, halt_d;
    logic        bp_en_q, bp_en_d;
    logic        bp_hit_q, bp_hit_d;
    logic        stepping_q, stepping_d;
    logic        halt_prev_q;
    logic        run_prev_q, step_prev_q;
    logic [31:0] dbp_q, dbp_d;
    logic [31:0] dscratch_q, dscratch_d;
    logic [31:0] data_in_q, data_in_d;

    logic        addr_ok;
    logic        wr_en, rd_en;
    logic        run_edge, step_edge;
    logic        halt_fell;
    logic        bp_match;
    logic [31:0] rd_data;

    assign addr_ok   = (address[31:4] == 28'd0) && (address[1:0] == 2'b00);
    assign wr_en     = enable & rd_wr & addr_ok;
    assign rd_en     = enable & ~rd_wr;
    assign run_edge  = run & ~run_prev_q;
    assign step_edge = step & ~step_prev_q;
    // Compare is masked for one cycle after release so a run/step off a
    // breakpoint can advance past it.
    assign halt_fell = halt_prev_q & ~halt_q;
    assign bp_match  = ~halt_q & bp_en_q & (pc == dbp_q) & ~halt_fell;

    always_comb begin
        rd_data = 32'd0;
        if (addr_ok) begin
            case (address[3:2])
                2'd0:    rd_data = {30'd0, bp_en_q, halt_q};
                2'd1:    rd_data = {29'd0, bp_hit_q, stepping_q, halt_q};
                2'd2:    rd_data = dbp_q;
                default: rd_data = dscratch_q;
            endcase
        end
    end

    always_comb begin
        halt_d     = halt_q;
        bp_en_d    = bp_en_q;
        bp_hit_d   = bp_hit_q;
        stepping_d = 1'b0;
        dbp_d      = dbp_q;
        dscratch_d = dscratch_q;
        data_in_d  = data_in_q;

        if (wr_en) begin
            case (address[3:2])
                2'd0:    bp_en_d    = data_out[1];
                2'd2:    dbp_d      = data_out;
                2'd3:    dscratch_d = data_out;
                default: ;
            endcase
        end

        if (rd_en) begin
            data_in_d = rd_data;
        end

        // Halt priority: run > step (incl. re-halt after a step) > DCTRL write > breakpoint.
        if (run_edge) begin
            halt_d   = 1'b0;
            bp_hit_d = 1'b0;
        end else if (step_edge && halt_q) begin
            halt_d     = 1'b0;
            stepping_d = 1'b1;
        end else if (stepping_q) begin
            halt_d = 1'b1;
        end else if (wr_en && address[3:2] == 2'd0) begin
            halt_d = data_out[0];
        end else if (bp_match) begin
            halt_d   = 1'b1;
            bp_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_q      <= 1'b0;
            bp_en_q     <= 1'b0;
            bp_hit_q    <= 1'b0;
            stepping_q  <= 1'b0;
            halt_prev_q <= 1'b0;
            run_prev_q  <= 1'b0;
            step_prev_q <= 1'b0;
            dbp_q       <= 32'd0;
            dscratch_q  <= 32'd0;
            data_in_q   <= 32'd0;
        end else begin
            halt_q      <= halt_d;
            bp_en_q     <= bp_en_d;
            bp_hit_q    <= bp_hit_d;
            stepping_q  <= stepping_d;
            halt_prev_q <= halt_q;
            run_prev_q  <= run;
            step_prev_q <= step;
            dbp_q       <= dbp_d;
            dscratch_q  <= dscratch_d;
            data_in_q   <= data_in_d;
        end
    end

    assign halt    = halt_q;
    assign data_in = data_in_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch, Jump;
    logic [3:0]  ALUControl;
    logic [31:0] pc;
    logic        enable;
    logic        rd_wr;
    logic [31:0] address;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        step;
    logic        run;
    logic        halt;

    always #5 clk = ~clk;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUOp      (ALUOp),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .Branch     (Branch),
        .Jump       (Jump),
        .ALUControl (ALUControl),
        .pc         (pc),
        .enable     (enable),
        .rd_wr      (rd_wr),
        .address    (address),
        .data_out   (data_out),
        .data_in    (data_in),
        .step       (step),
        .run        (run),
        .halt       (halt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- decode reference ----------------
    // Returns {RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, Jump, ALUOp[1:0]}
    function automatic logic [8:0] ref_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return 9'b1_0_0_0_0_0_0_10;
            7'b0010011: return 9'b1_1_0_0_0_0_0_11;
            7'b0000011: return 9'b1_1_1_0_1_0_0_00;
            7'b0100011: return 9'b0_1_0_1_0_0_0_00;
            7'b1100011: return 9'b0_0_0_0_0_1_0_01;
            7'b1101111, 7'b1100111: return 9'b1_1_0_0_0_0_1_00;
            7'b0110111, 7'b0010111: return 9'b1_1_0_0_0_0_0_00;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [1:0] aop, input logic [2:0] f3,
                                           input logic [6:0] f7);
        logic [3:0] base [8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (aop == 2'b00) return 4'd0;
        if (aop == 2'b01) return 4'd1;
        if (f3 == 3'd0 && aop == 2'b10 && f7[5]) return 4'd1;
        if (f3 == 3'd5 && f7[5]) return 4'd7;
        return base[f3];
    endfunction

    task automatic check_decode();
        logic [8:0] exp;
        #1;
        exp = ref_ctrl(opcode);
        check("ctrl", 32'({RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, Jump, ALUOp}),
              32'(exp));
        check("alu_control", 32'(ALUControl), 32'(ref_alu(exp[1:0], funct3, funct7)));
    endtask

    // ---------------- debug reference ----------------
    bit        m_halt, m_bp_en, m_bp_hit, m_stepping, m_halt_prev, m_run_prev, m_step_prev;
    bit [31:0] m_dbp, m_scratch, m_data_in;
    bit        n_halt, n_bp_en, n_bp_hit, n_stepping, n_halt_prev, n_run_prev, n_step_prev;
    bit [31:0] n_dbp, n_scratch, n_data_in;

    task automatic model_reset();
        {m_halt, m_bp_en, m_bp_hit, m_stepping, m_halt_prev, m_run_prev, m_step_prev} = '0;
        m_dbp = 0; m_scratch = 0; m_data_in = 0;
    endtask

    task automatic model_next();
        bit        valid, run_e, step_e, released_last, is_dctrl_wr;
        int        idx;
        bit [31:0] view;
        n_halt = m_halt; n_bp_en = m_bp_en; n_bp_hit = m_bp_hit; n_stepping = 0;
        n_dbp = m_dbp; n_scratch = m_scratch; n_data_in = m_data_in;
        n_halt_prev = m_halt; n_run_prev = run; n_step_prev = step;
        if (!reset) begin
            {n_halt, n_bp_en, n_bp_hit, n_halt_prev, n_run_prev, n_step_prev} = '0;
            n_dbp = 0; n_scratch = 0; n_data_in = 0;
            return;
        end
        valid  = (address % 4 == 0) && (address < 16);
        idx    = int'(address / 4);
        run_e  = run && !m_run_prev;
        step_e = step && !m_step_prev;
        released_last = m_halt_prev && !m_halt;
        is_dctrl_wr = enable && rd_wr && valid && idx == 0;
        if (enable && rd_wr && valid) begin
            if (idx == 0) n_bp_en = data_out[1];
            if (idx == 2) n_dbp = data_out;
            if (idx == 3) n_scratch = data_out;
        end
        if (enable && !rd_wr) begin
            view = 0;
            if (valid) begin
                case (idx)
                    0: view = m_halt + 2 * m_bp_en;
                    1: view = m_halt + 2 * m_stepping + 4 * m_bp_hit;
                    2: view = m_dbp;
                    default: view = m_scratch;
                endcase
            end
            n_data_in = view;
        end
        if (run_e) begin
            n_halt = 0; n_bp_hit = 0;
        end else if (step_e && m_halt) begin
            n_halt = 0; n_stepping = 1;
        end else if (m_stepping) begin
            n_halt = 1;
        end else if (is_dctrl_wr) begin
            n_halt = data_out[0];
        end else if (!m_halt && m_bp_en && pc == m_dbp && !released_last) begin
            n_halt = 1; n_bp_hit = 1;
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        m_halt = n_halt; m_bp_en = n_bp_en; m_bp_hit = n_bp_hit; m_stepping = n_stepping;
        m_halt_prev = n_halt_prev; m_run_prev = n_run_prev; m_step_prev = n_step_prev;
        m_dbp = n_dbp; m_scratch = n_scratch; m_data_in = n_data_in;
        @(negedge clk);
        check("halt", 32'(halt), 32'(m_halt));
        check("data_in", data_in, m_data_in);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1; rd_wr = 1'b1; address = a; data_out = d;
        tick();
        enable = 1'b0; rd_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        enable = 1'b1; rd_wr = 1'b0; address = a;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; pc = '0;
        enable = 1'b0; rd_wr = 1'b0; address = '0; data_out = '0; step = 1'b0; run = 1'b0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Load decode and ALU control corner cases.
        opcode = 7'b0000011;
        check_decode();
        check("load_ctrl", 32'({RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, ALUOp}),
              32'(7'b1110100));
        check("load_alu", 32'(ALUControl), 32'd0);
        opcode = 7'b0110011; funct3 = 3'b101; funct7 = 7'b0100000;
        check_decode();
        check("r_sra", 32'(ALUControl), 32'd7);
        opcode = 7'b0010011;
        check_decode();
        check("i_srai", 32'(ALUControl), 32'd7);
        funct3 = 3'b000;
        check_decode();
        check("i_addi_f7", 32'(ALUControl), 32'd0);
        opcode = '0; funct3 = '0; funct7 = '0;

        // Halt via DCTRL, status read, run release.
        wr(32'h0, 32'h1);
        check("dctrl_halt", 32'(halt), 32'd1);
        rd(32'h4);
        check("dstatus_halted", data_in, 32'h1);
        run = 1'b1; tick();
        check("run_release", 32'(halt), 32'd0);
        run = 1'b0; tick();

        // Single step while halted, step held high.
        wr(32'h0, 32'h1);
        step = 1'b1; tick();
        check("step_release", 32'(halt), 32'd0);
        enable = 1'b1; rd_wr = 1'b0; address = 32'h4;
        tick();
        enable = 1'b0;
        check("step_status", data_in, 32'h2);
        check("step_rehalt", 32'(halt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("step_held", 32'(halt), 32'd1);
        end
        step = 1'b0; tick();

        // Breakpoint.
        run = 1'b1; tick();
        run = 1'b0; tick();
        wr(32'h8, 32'h100);
        wr(32'h0, 32'h2);
        pc = 32'h100; tick();
        check("bp_halt", 32'(halt), 32'd1);
        rd(32'h4);
        check("bp_status", data_in, 32'h5);
        run = 1'b1; tick();
        check("bp_run", 32'(halt), 32'd0);
        tick();
        check("bp_suppress", 32'(halt), 32'd0);
        tick();
        run = 1'b0; pc = 32'h0; tick();
        run = 1'b1; tick();
        run = 1'b0; wr(32'h0, 32'h0);

        // Unmapped read, scratch, async reset mid-step.
        rd(32'h10);
        check("unmapped_rd", data_in, 32'h0);
        wr(32'hC, 32'hDEADBEEF);
        rd(32'hC);
        check("scratch_rd", data_in, 32'hDEADBEEF);
        wr(32'h0, 32'h3);
        step = 1'b1; tick();
        reset = 1'b0;
        #1;
        model_reset();
        check("async_halt", 32'(halt), 32'd0);
        check("async_data_in", data_in, 32'h0);
        @(negedge clk);
        step = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(32'(a * 4));
            check("post_reset_reg", data_in, 32'h0);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: opcode = 7'($urandom);
                1: opcode = 7'b0110011;
                2: opcode = 7'b0010011;
                default: begin
                    case ($urandom_range(0, 6))
                        0: opcode = 7'b0000011;
                        1: opcode = 7'b0100011;
                        2: opcode = 7'b1100011;
                        3: opcode = 7'b1101111;
                        4: opcode = 7'b1100111;
                        5: opcode = 7'b0110111;
                        default: opcode = 7'b0010111;
                    endcase
                end
            endcase
            funct3 = 3'($urandom);
            funct7 = $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom);
            check_decode();

            case ($urandom_range(0, 7))
                0: address = 32'h0;
                1: address = 32'h4;
                2: address = 32'h8;
                3: address = 32'hC;
                4: address = 32'h10;
                5: address = 32'h2;
                6: address = $urandom;
                default: address = 32'h0;
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2: begin enable = 1'b1; rd_wr = 1'b1; end
                3, 4, 5: begin enable = 1'b1; rd_wr = 1'b0; end
                default: begin enable = 1'b0; rd_wr = 1'($urandom); end
            endcase
            if (address == 32'h0) data_out = 32'($urandom_range(0, 3));
            else if (address == 32'h8) data_out = 32'($urandom_range(0, 7)) << 2;
            else data_out = $urandom;
            pc = $urandom_range(0, 1) ? m_dbp : 32'($urandom_range(0, 7)) << 2;
            run  = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
